bcd_addsub_seq: RTL
===================

// Module: bcd_addsub_seq
// PURPOSE
//  Parametrised NDIGITS-wide BCD adder/subtractor. Processes one digit per clock (LSD first) under a start/done handshake.
//  Sits between the switch/operand capture logic and the board 7-segment bank. Drives registered BCD result, flags, and
//  active-low segment codes.
//  Successor to the fixed 2-digit combinational adder: width-generic, add/sub mode, invalid-digit detection, registered output.
// PARAMETERS
//  NDIGITS   4   number of BCD digits per operand/result (>=1)
// PORTS
//  CLOCK_50  in   1            system clock, all logic rising-edge
//  RESET     in   1            synchronous, active-high reset
//  START     in   1            request; accepted only in IDLE
//  SUB       in   1            0 = A+B, 1 = A-B; sampled with START
//  A         in   4*NDIGITS    operand A, packed BCD, digit i at [4i+3:4i]
//  B         in   4*NDIGITS    operand B, packed BCD
//  BUSY      out  1            high in CHECK, CALC, FINISH
//  DONE      out  1            one-cycle pulse in FINISH; RESULT/flags valid from the same cycle
//  RESULT    out  4*NDIGITS    packed BCD result, held until next FINISH
//  OVF       out  1            add: carry out of MSD; sub: A<B (borrow out)
//  INVALID   out  1            any operand nibble > 9 at capture
//  HEX       out  7*NDIGITS    active-low segments [0:6] per digit, digit i at [7i+6:7i]
// BEHAVIOUR
//  Reset values: state=IDLE, BUSY=0, DONE=0, RESULT=0, OVF=0, INVALID=0. HEX shows all digits as "0" (7'b000_0001).
//  FSM: IDLE -> CHECK on START; CHECK -> FINISH if any nibble >9 (INVALID=1), else -> CALC.
//    CALC runs exactly NDIGITS cycles (digit counter 0..NDIGITS-1), then -> FINISH. FINISH -> IDLE unconditionally.
//  START accepted in IDLE only: A, B, SUB captured into operand regs that cycle. START in any other state is ignored
//    (no queueing).
//  Latency: valid op, START at cycle 0 -> DONE at cycle NDIGITS+2. Invalid op -> DONE at cycle 2.
//  CALC digit step (add): s = a_i + b_i + c. If s>9: digit = s+6 (low nibble), c=1; else digit = s, c=0. c cleared in CHECK.
//  CALC digit step (sub): d = a_i - b_i - br. If d<0: digit = d+10, br=1; else digit = d, br=0. br cleared in CHECK.
//  Digit results shift into a working reg MSD-ward. RESULT, OVF and INVALID load only in FINISH. On INVALID:
//    RESULT=0, OVF=0.
//  Overflow result: add keeps the low NDIGITS digits (wrap mod 10^NDIGITS); sub keeps the 10's-complement digits.
//    Both values are visible on RESULT.
//  HEX: per-digit decode of RESULT. All digits blank (7'b111_1111) while OVF or INVALID is set. Codes 0-9 as in
//    the shared segment table.
//  Flags and HEX are held through subsequent IDLE/CHECK/CALC until the next FINISH.
//  RESET asserted in any state returns to IDLE next edge. An in-flight op is discarded, DONE is not pulsed, and all
//    outputs take reset values.
//  SUB/A/B changes after capture have no effect on the in-flight op.
// STRUCTURE
//  Shared include bcd_defs.vh holds:
//    state encodings (IDLE/CHECK/CALC/FINISH);
//    SEG0..SEG9 and SEG_BLANK 7-bit active-low constants;
//    a digit-width localparam (4).
//  Sub-module bcd_to_seg7 (4-bit in, 7-bit out, blank input): instantiated NDIGITS times via generate.
//    Nibbles >9 decode to SEG_BLANK.
//  Top holds FSM, digit counter ($clog2(NDIGITS) bits, min 1), carry/borrow bit, operand shift regs, result reg.
// TESTING (NDIGITS=2 unless noted)
//  A=0x45 B=0x37 SUB=0 START@0 -> DONE@4, RESULT=0x82, OVF=0, INVALID=0, HEX={SEG8,SEG2}.
//  A=0x99 B=0x01 SUB=0 -> DONE@4, RESULT=0x00, OVF=1, HEX all 7'b111_1111.
//  A=0x20 B=0x35 SUB=1 -> DONE@4, RESULT=0x85, OVF=1. Then A=0x35 B=0x20 SUB=1 -> RESULT=0x15, OVF=0.
//  A=0x1A B=0x00 START@0 -> DONE@2, INVALID=1, RESULT=0x00, HEX blank. START pulses at cycles 1-3 ignored
//    (single DONE).
//  RESET asserted mid-CALC -> next cycle BUSY=0, RESULT=0, no DONE. A new START completes normally.
//  NDIGITS=4: A=0x9999 B=0x0001 SUB=0 -> DONE@6, RESULT=0x0000, OVF=1. A=0x1234 B=0x5678 -> RESULT=0x6912, OVF=0.

Source files
------------

// File: rtl/bcd_addsub_seq_pkg.sv
// Shared definitions for the sequential BCD adder/subtractor.
//   - FSM state encodings (IDLE/CHECK/CALC/FINISH)
//   - Active-low 7-segment constants SEG0..SEG9 and SEG_BLANK, bit order [0:6]
//   - Digit width and a nibble-to-segment helper
package bcd_addsub_seq_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [6:0] SEG0      = 7'b000_0001;
  localparam logic [6:0] SEG1      = 7'b100_1111;
  localparam logic [6:0] SEG2      = 7'b001_0010;
  localparam logic [6:0] SEG3      = 7'b000_0110;
  localparam logic [6:0] SEG4      = 7'b100_1100;
  localparam logic [6:0] SEG5      = 7'b010_0100;
  localparam logic [6:0] SEG6      = 7'b010_0000;
  localparam logic [6:0] SEG7      = 7'b000_1111;
  localparam logic [6:0] SEG8      = 7'b000_0000;
  localparam logic [6:0] SEG9      = 7'b000_0100;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Non-decimal nibbles decode to a blank digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEG0;
      4'd1:    seg_of = SEG1;
      4'd2:    seg_of = SEG2;
      4'd3:    seg_of = SEG3;
      4'd4:    seg_of = SEG4;
      4'd5:    seg_of = SEG5;
      4'd6:    seg_of = SEG6;
      4'd7:    seg_of = SEG7;
      4'd8:    seg_of = SEG8;
      4'd9:    seg_of = SEG9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Single-digit BCD to active-low 7-segment decoder.
// Ports:
//   i_bin   - BCD nibble
//   i_blank - force all segments off
//   o_seg   - active-low segments [0:6]
module bcd_to_seg7
  import bcd_addsub_seq_pkg::*;
(
  input  logic [3:0] i_bin,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) o_seg = seg_of(i_bin);
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Sequential NDIGITS-wide BCD adder/subtractor, one digit per clock, LSD first.
// Ports:
//   CLOCK_50  - clock, rising edge
//   RESET     - synchronous active-high reset
//   START     - request, accepted only in IDLE
//   SUB       - 0: A+B, 1: A-B (captured with START)
//   A, B      - packed BCD operands, digit i at [4i+3:4i]
//   BUSY      - high in CHECK, CALC, FINISH
//   DONE      - one-cycle pulse in FINISH; RESULT/flags valid that cycle
//   RESULT    - packed BCD result, held until next FINISH
//   OVF       - add: carry out of MSD; sub: borrow out (A<B)
//   INVALID   - an operand nibble was >9 at capture
//   HEX       - active-low segments per digit, digit i at [7i+6:7i]
//   DBG_STATE - current FSM state
//
// Handshake: START is a request qualified only by the FSM being in IDLE;
// requests in any other state are dropped, never queued. DONE is the
// completion strobe and RESULT/OVF/INVALID are valid while DONE is high
// and stay stable until the next DONE.
module bcd_addsub_seq
  import bcd_addsub_seq_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     SUB,
  input  logic [4*NDIGITS-1:0]     A,
  input  logic [4*NDIGITS-1:0]     B,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [4*NDIGITS-1:0]     RESULT,
  output logic                     OVF,
  output logic                     INVALID,
  output logic [7*NDIGITS-1:0]     HEX,
  output logic [1:0]               DBG_STATE
);

  localparam int W  = NDIGITS * DIGIT_W;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sub;
  logic          r_cy;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_result;
  logic          r_ovf;
  logic          r_invalid;

  logic          w_bad;
  logic          w_last;
  logic [4:0]    w_sum;
  logic [4:0]    w_diff;
  logic [3:0]    w_digit;
  logic          w_cy_next;
  logic [W-1:0]  w_work_next;
  logic          w_blank;

  // Any non-decimal nibble in the captured operands.
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  // One digit step on the low nibbles of the operand shift registers.
  // The 5-bit intermediates keep the carry/borrow in bit 4.
  always_comb begin
    w_sum     = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_cy};
    w_diff    = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'd0, r_cy};
    w_digit   = 4'd0;
    w_cy_next = 1'b0;
    if (r_sub) begin
      if (w_diff[4]) begin
        w_digit   = w_diff[3:0] + 4'd10;
        w_cy_next = 1'b1;
      end else begin
        w_digit   = w_diff[3:0];
      end
    end else begin
      if (w_sum > 5'd9) begin
        w_digit   = w_sum[3:0] + 4'd6;
        w_cy_next = 1'b1;
      end else begin
        w_digit   = w_sum[3:0];
      end
    end
  end

  // New digit enters at the MSD end; after NDIGITS steps the LSD has
  // walked down to the bottom nibble.
  assign w_work_next = (r_work >> DIGIT_W) | (W'(w_digit) << (W - DIGIT_W));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (START) w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = w_bad ? ST_FINISH : ST_CALC;
      ST_CALC:   if (w_last) w_state_next = ST_FINISH;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Result and flags are written on the edge that enters FINISH so they
  // are already valid while DONE is high.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_cy      <= 1'b0;
      r_cnt     <= '0;
      r_work    <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_a   <= A;
            r_b   <= B;
            r_sub <= SUB;
          end
        end
        ST_CHECK: begin
          r_cy   <= 1'b0;
          r_cnt  <= '0;
          r_work <= '0;
          if (w_bad) begin
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_invalid <= 1'b1;
          end
        end
        ST_CALC: begin
          r_a    <= r_a >> DIGIT_W;
          r_b    <= r_b >> DIGIT_W;
          r_cy   <= w_cy_next;
          r_work <= w_work_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_result  <= w_work_next;
            r_ovf     <= w_cy_next;
            r_invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = (r_state == ST_FINISH);
  assign RESULT    = r_result;
  assign OVF       = r_ovf;
  assign INVALID   = r_invalid;
  assign DBG_STATE = r_state;
  assign w_blank   = r_ovf | r_invalid;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .i_bin   (r_result[4*g +: 4]),
      .i_blank (w_blank),
      .o_seg   (HEX[7*g +: 7])
    );
  end

endmodule
